// File: rtl/sync_fifo_if.sv
// Handshake bundle for sync_fifo: write port, FWFT read port and status.
// Status signals are only live when the FIFO is built with SYNC_FIFO_STAT_EN.
interface sync_fifo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              clr;
  logic [DATA_W-1:0] din;
  logic              din_dv;
  logic              full;
  logic [DATA_W-1:0] dout;
  logic              dout_dv;
  logic              dout_rd;
  logic [ADDR_W:0]   level;
  logic              afull;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, din, din_dv, dout_rd,
    input  full, dout, dout_dv, level, afull, overflow, underflow
  );

  modport slave (
    input  clr, din, din_dv, dout_rd,
    output full, dout, dout_dv, level, afull, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO, 2^ADDR_W x DATA_W, with synchronous flush.
// Define SYNC_FIFO_STAT_EN to build the level/afull/overflow/underflow status logic.
module sync_fifo #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AFULL_THR = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  sync_fifo_if.slave     bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              full_q, full_d;
  logic              dv_q, dv_d;
  logic              wr_en, rd_en;

  // Accept decisions use registered full/valid so nothing combinational reaches outputs.
  always_comb begin
    wr_en    = bus.din_dv  && !full_q && !bus.clr;
    rd_en    = bus.dout_rd &&  dv_q   && !bus.clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    full_d = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
             (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
    dv_d   = (wr_ptr_d != rd_ptr_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      dv_q     <= dv_d;
    end
  end

  // Storage is deliberately not reset or flushed; pointers alone define contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.din;
  end

  assign bus.full    = full_q;
  assign bus.dout_dv = dv_q;
  assign bus.dout    = mem_q[rd_ptr_q[ADDR_W-1:0]];

`ifdef SYNC_FIFO_STAT_EN
  logic [PTR_W-1:0] level_q, level_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  always_comb begin
    level_d = wr_ptr_d - rd_ptr_d;
    afull_d = (level_d >= PTR_W'(AFULL_THR));
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (bus.clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (bus.din_dv  &&  full_q) ovf_d = 1'b1;
      if (bus.dout_rd && !dv_q)   udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign bus.level     = level_q;
  assign bus.afull     = afull_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
`else
  assign bus.level     = '0;
  assign bus.afull     = 1'b0;
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO: DATA_W-bit words, 2^ADDR_W entries, with full/empty backpressure, explicit read acknowledge, synchronous flush and optional level/error status. Successor to the fixed 16×1-bit FIFO for buffering data within one clock domain, e.g. between a serial front-end and a word-oriented consumer. The output is first-word-fall-through: the head word is presented on DOUT whenever DOUT_DV is high.

## Interface
- DATA_W, 8, word width in bits (≥1)
- ADDR_W, 4, address width; depth = 2^ADDR_W (≥2)
- AFULL_THR, 12, AFULL asserts when LEVEL ≥ AFULL_THR (1..2^ADDR_W)

- CLK  in  1  clock, all logic on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- CLR  in  1  synchronous flush
- DIN  in  DATA_W  write data
- DIN_DV  in  1  write request
- FULL  out  1  FIFO holds 2^ADDR_W words; writes are dropped
- DOUT  out  DATA_W  head word, valid while DOUT_DV=1
- DOUT_DV  out  1  FIFO not empty
- DOUT_RD  in  1  pop head word; acts only while DOUT_DV=1
- LEVEL  out  ADDR_W+1  stored word count (status)
- AFULL  out  1  LEVEL ≥ AFULL_THR (status)
- OVERFLOW  out  1  sticky: write attempted while FULL (status)
- UNDERFLOW  out  1  sticky: DOUT_RD while DOUT_DV=0 (status)

## Operation
- Storage: register array of 2^ADDR_W × DATA_W. Write and read pointers are ADDR_W+1 bits. The MSB is the wrap bit.
- Empty: pointers are equal. Full: low ADDR_W bits are equal and the MSBs differ. Pointers wrap modulo 2^(ADDR_W+1) with no special handling.
- Write accepted: DIN_DV=1 and FULL=0 and CLR=0. DIN is stored at wr_ptr and wr_ptr increments.
- Read accepted: DOUT_RD=1 and DOUT_DV=1 and CLR=0. rd_ptr increments.
- DOUT = mem[rd_ptr[ADDR_W-1:0]]. When DOUT_DV=0, DOUT is don't-care.
- Write and read in the same cycle:
  - Both are accepted independently and LEVEL is unchanged.
  - FULL is evaluated on the registered state. A write while FULL=1 is dropped even if a read is accepted in the same cycle.
  - DOUT_DV is also registered state. A read while empty is ignored even if a write lands in the same cycle.
- Dropped write: sets OVERFLOW and leaves storage and pointers unchanged.
- Ignored read: sets UNDERFLOW.
- CLR=1:
  - Both pointers go to 0, which empties the FIFO, and OVERFLOW/UNDERFLOW are cleared.
  - CLR overrides any write, read or error in the same cycle.
  - Memory contents are not cleared.
- Reset (RST_N=0): same effect as CLR, applied asynchronously. It may occur mid-stream. Data in flight is lost.
- Reset values: FULL=0, DOUT_DV=0, LEVEL=0, AFULL=0, OVERFLOW=0, UNDERFLOW=0.

## Timing
- Every output is a function of registers only. There is no combinational path from any input to any output.
- Write-to-read latency: a word written at edge k appears on DOUT with DOUT_DV=1 during the cycle after edge k, if the FIFO was empty.
- A pop at edge k presents the next word, or DOUT_DV=0, during the cycle after edge k.
- FULL, LEVEL and AFULL update on the same edge as the pointer change that causes them.
- With DIN_DV and DOUT_RD both held at 1 and the FIFO non-empty and non-full, throughput is one word per cycle in each direction.
- RST_N deassertion must be synchronous to CLK, via an external reset synchroniser. The first accepted write is on the first edge with RST_N=1.

## Configuration
- Macro SYNC_FIFO_STAT_EN.
- Defined: LEVEL, AFULL, OVERFLOW and UNDERFLOW behave as specified above.
- Not defined:
  - LEVEL, AFULL, OVERFLOW and UNDERFLOW are tied to 0.
  - The count logic, threshold compare and sticky flags are not synthesised.
  - FULL and DOUT_DV are still derived from the pointers.
  - The port list is identical in both builds.

## Test plan
- Fill and drain (ADDR_W=4, DATA_W=8, SYNC_FIFO_STAT_EN defined):
  - Write 0x00..0x0F on consecutive cycles → FULL=1 after the 16th edge, LEVEL=16, AFULL=1 from LEVEL=12.
  - Then pop 16 times → DOUT reads 0x00..0x0F in order, and DOUT_DV=0 after the 16th pop.
- Overflow: on a full FIFO, assert DIN_DV with DIN=0xAA and DOUT_RD=1 in the same cycle → write dropped, OVERFLOW=1, LEVEL=15. The 0xAA word never appears on DOUT.
- Underflow and empty race: on an empty FIFO, assert DOUT_RD=1 together with a write of 0x55 → UNDERFLOW=1, LEVEL=1, and DOUT=0x55 with DOUT_DV=1 on the next cycle.
- Wrap-around:
  - Stream 100 words with DIN_DV=DOUT_RD=1 continuously after 3 pre-filled words → LEVEL stays 3 throughout.
  - Output order matches input order across multiple pointer wraps.
- Flush and reset:
  - Assert CLR with 5 words stored and OVERFLOW=1 → next cycle LEVEL=0, DOUT_DV=0, OVERFLOW=0.
  - Drop RST_N mid-stream → all outputs go to their reset values immediately, without waiting for a clock edge.
- Macro off: repeat the fill/drain scenario → FIFO data and FULL are identical to the macro-on run, and LEVEL, AFULL, OVERFLOW and UNDERFLOW stay 0.
